program_loader: RTL
===================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The parameter MAX_WORDS SHALL default to 32768 and SHALL set the largest accepted program length in 32-bit words.
REQ-002 The parameter ACK_BYTE SHALL default to 8'hAA and SHALL be the byte sent once a load completes.
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-low, with ports named clk and rstn.
REQ-004 The port list SHALL be:
- clk  in  1  system clock
- rstn  in  1  async active-low reset
- rx_data  in  8  received UART byte
- rx_ready  in  1  one-cycle pulse, rx_data valid
- tx_busy  in  1  UART transmitter busy
- tx_start  out  1  one-cycle pulse, send tx_data
- tx_data  out  8  byte to transmit
- mem_we  out  1  instruction/data memory write enable
- mem_addr  out  32  word address
- mem_wdata  out  32  write data
- cpu_run  out  1  releases the CPU from hold
- load_err  out  1  length error, sticky until reset

Function
REQ-005 The protocol SHALL be a 4-byte length N, then N words of 4 bytes each, all big-endian (first byte lands in bits 31:24).
REQ-006 The FSM states SHALL be S_LEN, S_DATA, S_ACK, S_RUN and S_ERR.
REQ-007 After reset the FSM SHALL be in S_LEN.
REQ-008 Bytes SHALL be accepted only on cycles where rx_ready=1; rx_data SHALL be ignored otherwise.
REQ-009 In S_LEN, on the 4th byte: if N=0, go to S_ACK; if N>MAX_WORDS, go to S_ERR; otherwise go to S_DATA with word index k=0.
REQ-010 In S_DATA, the cycle after the 4th byte of word k is captured:
- mem_we=1 for exactly one cycle
- mem_addr=k
- mem_wdata=assembled word
REQ-011 mem_addr SHALL be a word address starting at 0 and incrementing by 1 per word.
REQ-012 A byte arriving in the same cycle as a mem_we pulse SHALL be captured as byte 0 of word k+1; no byte may be lost with rx_ready asserted every cycle.
REQ-013 After the write of word N-1, the FSM SHALL enter S_ACK on the next cycle.
REQ-014 In S_ACK, tx_data SHALL equal ACK_BYTE.
REQ-015 In S_ACK, tx_start SHALL pulse for one cycle on the first cycle with tx_busy=0, and the FSM SHALL then go to S_RUN.
REQ-016 If tx_busy stays high, the FSM SHALL wait in S_ACK indefinitely.
REQ-017 In S_RUN, cpu_run SHALL be 1 and held; rx_ready SHALL be ignored; the FSM SHALL stay in S_RUN until reset.
REQ-018 In S_ERR, load_err SHALL be 1 and cpu_run 0; no mem_we or tx_start SHALL occur; rx_ready SHALL be ignored; the FSM SHALL stay in S_ERR until reset.
REQ-019 mem_we SHALL never assert outside S_DATA, and tx_start SHALL never assert outside S_ACK.
REQ-020 The byte counter SHALL be 2 bits and wrap 3->0; the word counter SHALL be 32 bits and compare against N-1 without overflow.

Reset
REQ-021 On rstn=0, asynchronously: all outputs SHALL become 0; tx_data SHALL become 8'h00; the state SHALL become S_LEN; all counters and the assembly register SHALL clear.
REQ-022 Reset asserted mid-load SHALL discard the partial word and length; the next load SHALL start from a fresh length field.

Structure
REQ-023 The state encoding, ACK_BYTE default and protocol byte count (4) SHALL reside in a shared package, loader_pkg.
REQ-024 Byte-to-word assembly (shift register plus 2-bit byte counter with a word_valid pulse) SHALL be one sub-module, loader_word_asm, instantiated once and used for both the length and the data words.

Verification
REQ-025 Scenarios the bench SHALL cover:
- Send 00 00 00 02, 12 34 56 78, DE AD BE EF -> mem_we at addr 0 with 0x12345678, then addr 1 with 0xDEADBEEF; then one tx_start with tx_data=0xAA; then cpu_run=1.
- Send 00 00 00 00 -> no mem_we; tx_start with 0xAA; cpu_run=1.
- Send length MAX_WORDS+1 -> load_err=1; no mem_we or tx_start; cpu_run=0 for 1000 cycles.
- Hold tx_busy=1 for 50 cycles on entering S_ACK -> tx_start occurs on the first cycle after tx_busy falls; cpu_run stays 0 until then.
- Assert rstn=0 after 5 bytes of a 2-word load, then perform a full 1-word load (0xCAFEBABE) -> a single write at addr 0 with 0xCAFEBABE; cpu_run=1.
- Assert rx_ready every cycle for a 3-word load -> exactly 3 mem_we pulses, correct data, no dropped byte.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the UART program loader: FSM state encoding and
// protocol constants used by both the top level and the word assembler.
package loader_pkg;

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_ACK,
        S_RUN,
        S_ERR
    } state_t;

    localparam logic [7:0] ACK_BYTE_DEFAULT = 8'hAA;
    localparam int         BYTES_PER_WORD   = 4;
    localparam int         BYTE_CNT_W       = $clog2(BYTES_PER_WORD);

    // Big-endian assembly: earlier bytes move towards the MSB.
    function automatic logic [31:0] shift_in_byte(input logic [31:0] word,
                                                  input logic [7:0]  b);
        return {word[23:0], b};
    endfunction

endpackage

// File: rtl/loader_word_asm.sv
// Collects four big-endian bytes into a 32-bit word; word_valid pulses in the
// cycle the fourth byte is presented, with word_out already holding the result.
module loader_word_asm
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word_out
);

    logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]           shift_q, shift_d;

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (byte_valid) begin
            cnt_d   = cnt_q + BYTE_CNT_W'(1);
            shift_d = shift_in_byte(shift_q, byte_in);
        end
    end

    // The counter wraps on its own, so the next byte starts a fresh word.
    assign word_valid = byte_valid && (cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));
    assign word_out   = shift_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// UART boot loader: receives a length word then that many program words,
// writes them to memory, acknowledges with ACK_BYTE and releases the CPU.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 32768,
    parameter logic [7:0]  ACK_BYTE  = ACK_BYTE_DEFAULT
)(
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_run,
    output logic        load_err
);

    state_t      state_q, state_d;
    logic [31:0] len_q, len_d;
    logic [31:0] k_q, k_d;
    logic        last_q, last_d;
    logic        tx_start_q, tx_start_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        cpu_run_q, cpu_run_d;
    logic        load_err_q, load_err_d;

    logic        byte_valid;
    logic        asm_valid;
    logic [31:0] asm_word;

    // Bytes only matter while a load is in progress.
    assign byte_valid = rx_ready && ((state_q == S_LEN) || (state_q == S_DATA));

    loader_word_asm u_word_asm (
        .clk        (clk),
        .rstn       (rstn),
        .byte_valid (byte_valid),
        .byte_in    (rx_data),
        .word_valid (asm_valid),
        .word_out   (asm_word)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        k_d         = k_q;
        last_d      = last_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            S_LEN: begin
                if (asm_valid) begin
                    len_d  = asm_word;
                    k_d    = '0;
                    last_d = 1'b0;
                    if (asm_word == '0) begin
                        state_d = S_ACK;
                    end else if (asm_word > 32'(MAX_WORDS)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                // Stay here through the final write pulse, then acknowledge.
                if (mem_we_q && last_q) begin
                    state_d = S_ACK;
                end else if (asm_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = k_q;
                    mem_wdata_d = asm_word;
                    k_d         = k_q + 32'd1;
                    last_d      = (k_q == len_q - 32'd1);
                end
            end
            S_ACK: begin
                // tx_start is raised while still in S_ACK; leave once it has pulsed.
                if (tx_start_q) begin
                    state_d = S_RUN;
                end else if (!tx_busy) begin
                    tx_start_d = 1'b1;
                end
            end
            S_RUN: state_d = S_RUN;
            S_ERR: state_d = S_ERR;
            default: state_d = S_LEN;
        endcase

        if (state_d == S_ACK) begin
            tx_data_d = ACK_BYTE;
        end
        cpu_run_d  = (state_d == S_RUN);
        load_err_d = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_LEN;
            len_q       <= '0;
            k_q         <= '0;
            last_q      <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_run_q   <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            k_q         <= k_d;
            last_q      <= last_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_run_q   <= cpu_run_d;
            load_err_q  <= load_err_d;
        end
    end

    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_run   = cpu_run_q;
    assign load_err  = load_err_q;

endmodule
